// File: rtl/crossbar_2x2_switch.sv
// Buffered 2x2 packet switch: per-input FIFOs, per-output round-robin arbitration,
// registered outputs with valid/ready flow control.
module crossbar_2x2_switch #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_dest,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_dest,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_src,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_src,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic             conflict
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH:0]   mem [2][DEPTH];
    logic [AW-1:0]    wr_ptr_q [2];
    logic [AW-1:0]    rd_ptr_q [2];
    logic [CW-1:0]    count_q [2];

    logic [WIDTH-1:0] in_data [2];
    logic [1:0]       in_valid, in_dest, in_ready_w, push, pop;
    logic [WIDTH-1:0] head_data [2];
    logic [1:0]       head_dest;
    logic [1:0][1:0]  req, gnt;  // [input][output]
    logic [1:0]       out_ready, free;

    logic [WIDTH-1:0] out_data_q [2];
    logic [1:0]       out_src_q, out_valid_q, rr_q;
    logic             conflict_q;

    assign in_data[0] = in1_data;
    assign in_data[1] = in2_data;
    assign in_valid   = {in2_valid, in1_valid};
    assign in_dest    = {in2_dest, in1_dest};
    assign out_ready  = {out2_ready, out1_ready};

    // Ready comes from the registered count only, so a full FIFO stays closed on a pop cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_ready_w[i] = !rst && (count_q[i] < CW'(DEPTH));
            push[i]       = in_valid[i] && in_ready_w[i];
            {head_dest[i], head_data[i]} = mem[i][rd_ptr_q[i]];
            req[i][0]     = (count_q[i] != '0) && !head_dest[i];
            req[i][1]     = (count_q[i] != '0) && head_dest[i];
        end
    end

    always_comb begin
        for (int y = 0; y < 2; y++) begin
            free[y]   = !out_valid_q[y] || out_ready[y];
            gnt[0][y] = free[y] && req[0][y] && (!req[1][y] || !rr_q[y]);
            gnt[1][y] = free[y] && req[1][y] && (!req[0][y] || rr_q[y]);
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pop[i] = |gnt[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr_q[i]] <= {in_dest[i], in_data[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                count_q[i]    <= '0;
                out_data_q[i] <= '0;
            end
            out_src_q   <= '0;
            out_valid_q <= '0;
            rr_q        <= '0;
            conflict_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                if (push[i] && !pop[i])      count_q[i] <= count_q[i] + CW'(1);
                else if (!push[i] && pop[i]) count_q[i] <= count_q[i] - CW'(1);
            end
            for (int y = 0; y < 2; y++) begin
                if (gnt[0][y]) begin
                    out_data_q[y]  <= head_data[0];
                    out_src_q[y]   <= 1'b0;
                    out_valid_q[y] <= 1'b1;
                end else if (gnt[1][y]) begin
                    out_data_q[y]  <= head_data[1];
                    out_src_q[y]   <= 1'b1;
                    out_valid_q[y] <= 1'b1;
                end else if (out_ready[y]) begin
                    out_valid_q[y] <= 1'b0;
                end
                // Pointer only moves when contention was actually resolved by a grant.
                if (free[y] && req[0][y] && req[1][y]) rr_q[y] <= ~rr_q[y];
            end
            conflict_q <= |(req[0] & req[1]);
        end
    end

    assign in1_ready  = in_ready_w[0];
    assign in2_ready  = in_ready_w[1];
    assign out1_data  = out_data_q[0];
    assign out1_src   = out_src_q[0];
    assign out1_valid = out_valid_q[0];
    assign out2_data  = out_data_q[1];
    assign out2_src   = out_src_q[1];
    assign out2_valid = out_valid_q[1];
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_crossbar_2x2_switch.sv
// Scoreboard bench for crossbar_2x2_switch: directed vectors push expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_crossbar_2x2_switch;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in1_data, in2_data;
    logic       in1_dest, in2_dest, in1_valid, in2_valid, in1_ready, in2_ready;
    logic [3:0] out1_data, out2_data;
    logic       out1_src, out2_src, out1_valid, out2_valid, out1_ready, out2_ready;
    logic       conflict;

    int checks = 0;
    int errors = 0;
    logic [4:0] q1 [$];
    logic [4:0] q2 [$];
    int  accepted;
    int  conf_cnt;
    bit  count_conf = 1'b0;

    crossbar_2x2_switch #(.WIDTH(4), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in1_data(in1_data), .in1_dest(in1_dest), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .in2_data(in2_data), .in2_dest(in2_dest), .in2_valid(in2_valid), .in2_ready(in2_ready),
        .out1_data(out1_data), .out1_src(out1_src), .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_src(out2_src), .out2_valid(out2_valid),
        .out2_ready(out2_ready),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it stable until the handshake completes.
    task automatic send(input int port, input logic [3:0] d, input logic dst);
        int   n = 0;
        logic r = 1'b0;
        if (port == 1) begin in1_data = d; in1_dest = dst; in1_valid = 1'b1; end
        else           begin in2_data = d; in2_dest = dst; in2_valid = 1'b1; end
        while (!r && n < 50) begin
            @(negedge clk);
            r = (port == 1) ? in1_ready : in2_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) check($sformatf("in%0d accept timeout", port), 0, 1);
        if (port == 1) in1_valid = 1'b0;
        else           in2_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() + q2.size()) != 0 && n < 100) begin
            step();
            n++;
        end
        check("scoreboard drained", q1.size() + q2.size(), 0);
        repeat (2) step();
    endtask

    // Output monitor: pops on every accepted word, checks hold-while-stalled.
    initial begin
        logic [4:0] e, last1, last2;
        bit hold1 = 1'b0, hold2 = 1'b0;
        forever begin
            @(negedge clk);
            if (count_conf) conf_cnt += int'(conflict);
            if (rst) begin
                hold1 = 1'b0;
                hold2 = 1'b0;
            end else begin
                if (hold1) check("out1 held", int'({out1_valid, out1_src, out1_data}),
                                 int'({1'b1, last1}));
                if (hold2) check("out2 held", int'({out2_valid, out2_src, out2_data}),
                                 int'({1'b1, last2}));
                if (out1_valid && out1_ready) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out1 unexpected: got src=%0d data=%h, required none",
                                 out1_src, out1_data);
                    end else begin
                        e = q1.pop_front();
                        check("out1 word", int'({out1_src, out1_data}), int'(e));
                    end
                end
                if (out2_valid && out2_ready) begin
                    if (q2.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out2 unexpected: got src=%0d data=%h, required none",
                                 out2_src, out2_data);
                    end else begin
                        e = q2.pop_front();
                        check("out2 word", int'({out2_src, out2_data}), int'(e));
                    end
                end
                hold1 = out1_valid && !out1_ready;
                hold2 = out2_valid && !out2_ready;
                last1 = {out1_src, out1_data};
                last2 = {out2_src, out2_data};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {in1_data, in2_data, in1_dest, in2_dest, in1_valid, in2_valid} = '0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        #1;
        check("reset in_ready", int'({in1_ready, in2_ready}), 0);
        check("reset out_valid", int'({out1_valid, out2_valid}), 0);
        check("reset out data/src", int'({out1_src, out1_data, out2_src, out2_data}), 0);
        check("reset conflict", int'(conflict), 0);
        step(); step();
        rst = 1'b0;
        #1;
        check("post-reset in_ready", int'({in1_ready, in2_ready}), 3);

        // Bar routing
        q1.push_back({1'b0, 4'h3});
        q2.push_back({1'b1, 4'hC});
        fork
            send(1, 4'h3, 1'b0);
            send(2, 4'hC, 1'b1);
        join
        check("bar latency edge1", int'({out1_valid, out2_valid}), 0);
        step();
        check("bar both valid", int'({out1_valid, out2_valid}), 3);
        check("bar conflict", int'(conflict), 0);
        drain();

        // Cross routing
        q2.push_back({1'b0, 4'hA});
        q1.push_back({1'b1, 4'h5});
        fork
            send(1, 4'hA, 1'b1);
            send(2, 4'h5, 1'b0);
        join
        step();
        check("cross both valid", int'({out1_valid, out2_valid}), 3);
        check("cross conflict", int'(conflict), 0);
        drain();

        // Contention on out1: round-robin interleave
        foreach (q1[i]) ;
        q1.push_back({1'b0, 4'h1}); q1.push_back({1'b1, 4'h9});
        q1.push_back({1'b0, 4'h2}); q1.push_back({1'b1, 4'h8});
        q1.push_back({1'b0, 4'h3}); q1.push_back({1'b1, 4'h7});
        conf_cnt   = 0;
        count_conf = 1'b1;
        fork
            begin send(1, 4'h1, 1'b0); send(1, 4'h2, 1'b0); send(1, 4'h3, 1'b0); end
            begin send(2, 4'h9, 1'b0); send(2, 4'h8, 1'b0); send(2, 4'h7, 1'b0); end
        join
        drain();
        count_conf = 1'b0;
        check("contention conflict pulses", conf_cnt, 5);

        // Backpressure / full
        out1_ready = 1'b0;
        accepted   = 0;
        for (int k = 4; k < 8; k++) q1.push_back({1'b0, 4'(k)});
        fork
            for (int k = 4; k < 8; k++) begin
                send(1, 4'(k), 1'b0);
                accepted++;
            end
        join_none
        repeat (6) step();
        check("full accepts", accepted, 3);
        check("full in1_ready", int'(in1_ready), 0);
        repeat (2) begin
            step();
            check("stalled out1", int'({out1_valid, out1_data}), int'({1'b1, 4'h4}));
        end
        out1_ready = 1'b1;
        step();
        check("in1_ready reasserts", int'(in1_ready), 1);
        for (int n = 0; n < 20 && accepted < 4; n++) step();
        check("all four accepted", accepted, 4);
        drain();

        // Head-of-line blocking
        out1_ready = 1'b0;
        q1.push_back({1'b0, 4'h1}); q1.push_back({1'b0, 4'h2});
        q2.push_back({1'b0, 4'h3});
        send(1, 4'h1, 1'b0);
        send(1, 4'h2, 1'b0);
        send(1, 4'h3, 1'b1);
        repeat (3) begin
            step();
            check("HOL out2 blocked", int'(out2_valid), 0);
        end
        out1_ready = 1'b1;
        drain();

        // Asynchronous reset mid-stream
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        fork
            begin send(1, 4'hD, 1'b0); send(1, 4'hE, 1'b0); send(1, 4'hF, 1'b0); end
            begin send(2, 4'h1, 1'b1); send(2, 4'h2, 1'b1); send(2, 4'h4, 1'b1); end
        join
        step();
        check("pre-reset outputs busy", int'({out1_valid, out2_valid}), 3);
        #2 rst = 1'b1;
        #1;
        check("async reset out_valid", int'({out1_valid, out2_valid}), 0);
        check("async reset out data", int'({out1_src, out1_data, out2_src, out2_data}), 0);
        check("async reset in_ready", int'({in1_ready, in2_ready}), 0);
        check("async reset conflict", int'(conflict), 0);
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        check("no stale output", int'({out1_valid, out2_valid}), 0);
        q1.push_back({1'b1, 4'h6});
        send(2, 4'h6, 1'b0);
        check("post-reset latency edge1", int'(out1_valid), 0);
        step();
        check("post-reset word", int'({out1_valid, out1_src, out1_data}),
              int'({1'b1, 1'b1, 4'h6}));
        drain();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
